// File: rtl/clock_pkg.sv
// Shared types and constants for the alarm clock controller: FSM states,
// BCD time layout, field limits and the one-hot field select used by flash.
package clock_pkg;

   localparam int DIGIT_W = 4;

   typedef struct packed {
      logic [2*DIGIT_W-1:0] h;
      logic [2*DIGIT_W-1:0] m;
      logic [2*DIGIT_W-1:0] s;
   } time_t;

   localparam logic [7:0] MAX_SEC  = 8'h59;
   localparam logic [7:0] MAX_MIN  = 8'h59;
   localparam logic [7:0] MAX_HOUR = 8'h23;

   // One-hot field select, bit order matches flash {hour,min,sec}
   localparam logic [2:0] FLD_NONE = 3'b000;
   localparam logic [2:0] FLD_SEC  = 3'b001;
   localparam logic [2:0] FLD_MIN  = 3'b010;
   localparam logic [2:0] FLD_HOUR = 3'b100;

   typedef enum logic [2:0] {
      ST_RUN,
      ST_T_SEC,
      ST_T_MIN,
      ST_T_HOUR,
      ST_A_SEC,
      ST_A_MIN,
      ST_A_HOUR
   } state_t;

   // Two-digit BCD increment that wraps to 00 after max
   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
      if (v == max) return 8'h00;
      if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
      return v + 8'd1;
   endfunction

endpackage

// File: rtl/bcd_time_reg.sv
// 24-bit BCD time register: tick advances seconds with full carry (unless
// frozen); inc bumps individual fields with wrap and no carry.
module bcd_time_reg
   import clock_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        tick,
   input  logic [2:0]  inc,
   input  logic        freeze,
   output logic [23:0] value
);

   time_t cur;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur <= '0;
      end else if (tick && !freeze) begin
         cur.s <= bcd_inc(cur.s, MAX_SEC);
         if (cur.s == MAX_SEC) begin
            cur.m <= bcd_inc(cur.m, MAX_MIN);
            if (cur.m == MAX_MIN) cur.h <= bcd_inc(cur.h, MAX_HOUR);
         end
      end else begin
         if (inc[0]) cur.s <= bcd_inc(cur.s, MAX_SEC);
         if (inc[1]) cur.m <= bcd_inc(cur.m, MAX_MIN);
         if (inc[2]) cur.h <= bcd_inc(cur.h, MAX_HOUR);
      end
   end

   assign value = cur;

endmodule

// File: rtl/alarm_clock_ctrl.sv
// Clock/alarm controller: BCD time of day, NUM_ALARMS alarms, set-mode FSM
// driven by button pulses, timed ringing with dismiss and a gated buzzer.
module alarm_clock_ctrl
   import clock_pkg::*;
#(
   parameter int CLK_HZ       = 50_000_000,
   parameter int NUM_ALARMS   = 4,
   parameter int RING_SECONDS = 60,
   parameter int BEEP_DIV     = 6_250_000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  set_pulse,
   input  logic                  add_pulse,
   input  logic                  beep_pulse,
   output logic [23:0]           time_bcd,
   output logic [2:0]            flash,
   output logic [2:0]            alarm_idx,
   output logic [NUM_ALARMS-1:0] alarm_en,
   output logic                  ringing,
   output logic                  beep_out
);

   localparam int                 PRESC_W    = $clog2(CLK_HZ + 1);
   localparam logic [PRESC_W-1:0] PRESC_MAX  = PRESC_W'(CLK_HZ - 1);
   localparam int                 BEEP_W     = $clog2(BEEP_DIV + 1);
   localparam logic [BEEP_W-1:0]  BEEP_MAX   = BEEP_W'(BEEP_DIV - 1);
   localparam logic [7:0]         RING_LAST  = 8'(RING_SECONDS - 1);
   localparam logic [2:0]         LAST_ALARM = 3'(NUM_ALARMS - 1);

   state_t                  state_q, state_d;
   logic [2:0]              sel_q, sel_d;
   logic [PRESC_W-1:0]      presc_q;
   logic [BEEP_W-1:0]       beep_cnt_q;
   logic                    sq_q;
   logic [7:0]              ring_cnt_q;
   logic                    ring_q;
   logic                    tick_q;
   logic [NUM_ALARMS-1:0]   en_q;

   logic                    in_set_time, in_set_alarm;
   logic [2:0]              field;
   logic                    tick, hit, add_ok;
   logic [2:0]              time_inc;
   logic [23:0]             cur_time;
   logic [23:0]             alarm_time [NUM_ALARMS];
   logic [2:0]              alarm_inc  [NUM_ALARMS];
   logic [NUM_ALARMS-1:0]   match, en_toggle;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_RUN;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      in_set_time  = 1'b0;
      in_set_alarm = 1'b0;
      field        = FLD_NONE;
      case (state_q)
         ST_RUN: if (set_pulse) state_d = ST_T_SEC;
         ST_T_SEC: begin
            in_set_time = 1'b1;
            field       = FLD_SEC;
            if (set_pulse) state_d = ST_T_MIN;
         end
         ST_T_MIN: begin
            in_set_time = 1'b1;
            field       = FLD_MIN;
            if (set_pulse) state_d = ST_T_HOUR;
         end
         ST_T_HOUR: begin
            in_set_time = 1'b1;
            field       = FLD_HOUR;
            if (set_pulse) begin
               state_d = ST_A_SEC;
               sel_d   = '0;
            end
         end
         ST_A_SEC: begin
            in_set_alarm = 1'b1;
            field        = FLD_SEC;
            if (set_pulse) state_d = ST_A_MIN;
         end
         ST_A_MIN: begin
            in_set_alarm = 1'b1;
            field        = FLD_MIN;
            if (set_pulse) state_d = ST_A_HOUR;
         end
         ST_A_HOUR: begin
            in_set_alarm = 1'b1;
            field        = FLD_HOUR;
            if (set_pulse) begin
               if (sel_q == LAST_ALARM) begin
                  state_d = ST_RUN;
                  sel_d   = '0;
               end else begin
                  state_d = ST_A_SEC;
                  sel_d   = sel_q + 3'd1;
               end
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   // Prescaler held at 0 while time is being set so counting restarts cleanly
   assign tick     = !in_set_time && (presc_q == PRESC_MAX);
   assign add_ok   = add_pulse && !set_pulse;
   assign time_inc = (in_set_time && add_ok) ? field : FLD_NONE;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                    presc_q <= '0;
      else if (in_set_time || tick) presc_q <= '0;
      else                         presc_q <= presc_q + 1'b1;
   end

   bcd_time_reg u_time (
      .clk    (clk),
      .rst    (rst),
      .tick   (tick),
      .inc    (time_inc),
      .freeze (in_set_time),
      .value  (cur_time)
   );

   for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_alarm
      bcd_time_reg u_alarm (
         .clk    (clk),
         .rst    (rst),
         .tick   (1'b0),
         .inc    (alarm_inc[g]),
         .freeze (1'b0),
         .value  (alarm_time[g])
      );
   end

   always_comb begin
      for (int unsigned g = 0; g < NUM_ALARMS; g++) begin
         alarm_inc[g] = (in_set_alarm && add_ok && sel_q == 3'(g)) ? field : FLD_NONE;
         en_toggle[g] = in_set_alarm && beep_pulse && sel_q == 3'(g);
         match[g]     = en_q[g] && (alarm_time[g] == cur_time);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) en_q <= '0;
      else      en_q <= en_q ^ en_toggle;
   end

   // Compare one cycle after a tick so the freshly updated time is used
   assign hit = tick_q && (state_q == ST_RUN) && (|match);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tick_q     <= 1'b0;
         ring_q     <= 1'b0;
         ring_cnt_q <= '0;
      end else begin
         tick_q <= tick;
         if (set_pulse || (state_q == ST_RUN && beep_pulse)) begin
            ring_q <= 1'b0;
         end else if (hit) begin
            ring_q     <= 1'b1;
            ring_cnt_q <= '0;
         end else if (ring_q && tick) begin
            if (ring_cnt_q == RING_LAST) ring_q <= 1'b0;
            else                         ring_cnt_q <= ring_cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         beep_cnt_q <= '0;
         sq_q       <= 1'b0;
      end else if (beep_cnt_q == BEEP_MAX) begin
         beep_cnt_q <= '0;
         sq_q       <= ~sq_q;
      end else begin
         beep_cnt_q <= beep_cnt_q + 1'b1;
      end
   end

   always_comb begin
      time_bcd = cur_time;
      if (in_set_alarm) begin
         for (int unsigned g = 0; g < NUM_ALARMS; g++) begin
            if (sel_q == 3'(g)) time_bcd = alarm_time[g];
         end
      end
   end

   assign flash     = field;
   assign alarm_idx = in_set_alarm ? sel_q : 3'd0;
   assign alarm_en  = en_q;
   assign ringing   = ring_q;
   assign beep_out  = ring_q & sq_q;

endmodule

// File: tb/tb_alarm_clock_ctrl.sv
// Bench for alarm_clock_ctrl: directed scenarios plus random pulses, every
// cycle compared against a seconds-of-day reference model.
module tb_alarm_clock_ctrl;

   localparam int CLK_HZ       = 10;
   localparam int NUM_ALARMS   = 2;
   localparam int RING_SECONDS = 3;
   localparam int BEEP_DIV     = 2;
   localparam int NUM_STEPS    = 4 + 3 * NUM_ALARMS;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  set_pulse = 1'b0;
   logic                  add_pulse = 1'b0;
   logic                  beep_pulse = 1'b0;
   logic [23:0]           time_bcd;
   logic [2:0]            flash;
   logic [2:0]            alarm_idx;
   logic [NUM_ALARMS-1:0] alarm_en;
   logic                  ringing;
   logic                  beep_out;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: step 0 = RUN, 1..3 = time fields, 4+3k+f = alarm k field f
   int                    m_step, m_time, m_presc, m_ring_ticks, m_edges;
   int                    m_alarm [NUM_ALARMS];
   bit [NUM_ALARMS-1:0]   m_en;
   bit                    m_tick_prev, m_ring;

   always #5 clk = ~clk;

   alarm_clock_ctrl #(
      .CLK_HZ       (CLK_HZ),
      .NUM_ALARMS   (NUM_ALARMS),
      .RING_SECONDS (RING_SECONDS),
      .BEEP_DIV     (BEEP_DIV)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .set_pulse  (set_pulse),
      .add_pulse  (add_pulse),
      .beep_pulse (beep_pulse),
      .time_bcd   (time_bcd),
      .flash      (flash),
      .alarm_idx  (alarm_idx),
      .alarm_en   (alarm_en),
      .ringing    (ringing),
      .beep_out   (beep_out)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [23:0] to_bcd(input int secs);
      int h, mi, s;
      h  = secs / 3600;
      mi = (secs / 60) % 60;
      s  = secs % 60;
      return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   function automatic int bump(input int secs, input int f);
      int h, mi, s;
      h  = secs / 3600;
      mi = (secs / 60) % 60;
      s  = secs % 60;
      case (f)
         0:       s  = (s + 1) % 60;
         1:       mi = (mi + 1) % 60;
         default: h  = (h + 1) % 24;
      endcase
      return h * 3600 + mi * 60 + s;
   endfunction

   task automatic model_reset();
      m_step = 0; m_time = 0; m_presc = 0; m_ring_ticks = 0; m_edges = 0;
      m_en = '0; m_tick_prev = 0; m_ring = 0;
      for (int i = 0; i < NUM_ALARMS; i++) m_alarm[i] = 0;
   endtask

   task automatic model_step(input bit s_in, input bit a_in, input bit b_in);
      bit in_t, in_a, tick, hit;
      int k, f;
      in_t = (m_step >= 1) && (m_step <= 3);
      in_a = (m_step >= 4);
      k    = in_a ? (m_step - 4) / 3 : 0;
      f    = in_a ? (m_step - 4) % 3 : m_step - 1;
      tick = !in_t && (m_presc == CLK_HZ - 1);
      hit  = 0;
      if (m_tick_prev && m_step == 0)
         for (int i = 0; i < NUM_ALARMS; i++)
            if (m_en[i] && m_alarm[i] == m_time) hit = 1;
      if (s_in || (m_step == 0 && b_in)) m_ring = 0;
      else if (hit) begin
         m_ring = 1;
         m_ring_ticks = 0;
      end else if (m_ring && tick) begin
         m_ring_ticks++;
         if (m_ring_ticks == RING_SECONDS) m_ring = 0;
      end
      if (tick) m_time = (m_time + 1) % 86400;
      else if (in_t && a_in && !s_in) m_time = bump(m_time, f);
      m_presc = (in_t || tick) ? 0 : m_presc + 1;
      if (in_a && a_in && !s_in) m_alarm[k] = bump(m_alarm[k], f);
      if (in_a && b_in) m_en[k] = ~m_en[k];
      m_tick_prev = tick;
      if (s_in) m_step = (m_step + 1) % NUM_STEPS;
      m_edges++;
   endtask

   task automatic check_model();
      bit in_a;
      int k, f;
      in_a = (m_step >= 4);
      k    = in_a ? (m_step - 4) / 3 : 0;
      f    = in_a ? (m_step - 4) % 3 : m_step - 1;
      check_eq("time_bcd", time_bcd, to_bcd(in_a ? m_alarm[k] : m_time));
      check_eq("flash", flash, (m_step == 0) ? 0 : (1 << f));
      check_eq("alarm_idx", alarm_idx, k);
      check_eq("alarm_en", alarm_en, m_en);
      check_eq("ringing", ringing, m_ring);
      check_eq("beep_out", beep_out, m_ring && ((m_edges / BEEP_DIV) % 2 == 1));
   endtask

   // Entered just after a falling edge; returns just after the next one
   task automatic cycle(input bit s_in, input bit a_in, input bit b_in);
      set_pulse = s_in; add_pulse = a_in; beep_pulse = b_in;
      @(posedge clk);
      model_step(s_in, a_in, b_in);
      #1 check_model();
      @(negedge clk);
      set_pulse = 0; add_pulse = 0; beep_pulse = 0;
   endtask

   task automatic pulse(input bit s_in, input bit a_in, input bit b_in);
      cycle(s_in, a_in, b_in);
      cycle(0, 0, 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0);
   endtask

   task automatic check_reset_outputs();
      check_eq("rst_time", time_bcd, 24'h000000);
      check_eq("rst_flash", flash, 3'b000);
      check_eq("rst_idx", alarm_idx, 3'd0);
      check_eq("rst_en", alarm_en, '0);
      check_eq("rst_ringing", ringing, 1'b0);
      check_eq("rst_beep", beep_out, 1'b0);
   endtask

   task automatic async_reset();
      #2 rst = 0;
      #1 check_reset_outputs();
      model_reset();
      @(negedge clk);
      rst = 1;
   endtask

   task automatic wait_ring(input string tag, input int limit);
      for (int i = 0; i < limit && !ringing; i++) cycle(0, 0, 0);
      check_eq(tag, ringing, 1'b1);
   endtask

   initial begin
      #200_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      model_reset();
      #1 rst = 0;
      #6 check_reset_outputs();
      @(negedge clk);
      rst = 1;

      // Time set: seconds wrap without carry, time stays frozen
      pulse(1, 0, 0);
      repeat (61) pulse(0, 1, 0);
      check_eq("sec_wrap61", time_bcd, 24'h000001);
      check_eq("flash_tsec", flash, 3'b001);
      idle(1000);
      check_eq("frozen", time_bcd, 24'h000001);
      repeat (56) pulse(0, 1, 0);
      pulse(1, 0, 0);
      repeat (59) pulse(0, 1, 0);
      pulse(1, 1, 0);
      check_eq("set_add_min", time_bcd, 24'h005957);
      check_eq("set_add_flash", flash, 3'b100);
      repeat (23) pulse(0, 1, 0);
      check_eq("preset", time_bcd, 24'h235957);

      // Alarm 1 = 00:00:05, enabled; run across midnight into the ring
      pulse(1, 0, 0);
      repeat (3) pulse(1, 0, 0);
      check_eq("a1_idx", alarm_idx, 3'd1);
      check_eq("a1_init", time_bcd, 24'h000000);
      repeat (5) pulse(0, 1, 0);
      check_eq("a1_sec", time_bcd, 24'h000005);
      pulse(0, 0, 1);
      check_eq("a1_en", alarm_en, 2'b10);
      repeat (3) pulse(1, 0, 0);
      check_eq("run_flash", flash, 3'b000);
      check_eq("run_idx", alarm_idx, 3'd0);
      wait_ring("ring_rise", 300);
      check_eq("ring_at_05", time_bcd, 24'h000005);
      n = 0;
      for (int i = 0; i < 100 && ringing; i++) begin
         n++;
         cycle(0, 0, 0);
      end
      check_eq("ring_len", n, 29);

      // Alarm 0 = 00:00:20, dismissed by beep
      repeat (4) pulse(1, 0, 0);
      repeat (20) pulse(0, 1, 0);
      pulse(0, 0, 1);
      check_eq("both_en", alarm_en, 2'b11);
      repeat (6) pulse(1, 0, 0);
      wait_ring("ring2_rise", 300);
      idle(10);
      cycle(0, 0, 1);
      check_eq("dismiss", ringing, 1'b0);
      check_eq("dismiss_beep", beep_out, 1'b0);

      // Alarm 0 moved to 00:00:30, ring ended by set
      repeat (4) pulse(1, 0, 0);
      repeat (10) pulse(0, 1, 0);
      repeat (6) pulse(1, 0, 0);
      wait_ring("ring3_rise", 300);
      idle(5);
      cycle(1, 0, 0);
      check_eq("set_ends_ring", ringing, 1'b0);
      check_eq("set_to_tsec", flash, 3'b001);

      // Reset while setting alarm 0 minutes
      repeat (4) pulse(1, 0, 0);
      check_eq("amin_flash", flash, 3'b010);
      async_reset();
      idle(3);

      // Reset mid-ring
      repeat (4) pulse(1, 0, 0);
      repeat (4) pulse(0, 1, 0);
      pulse(0, 0, 1);
      repeat (6) pulse(1, 0, 0);
      wait_ring("ring4_rise", 300);
      idle(7);
      async_reset();
      idle(5);

      // Random pulses, including coincident ones
      for (int i = 0; i < 4000; i++) begin
         bit s_r, a_r, b_r;
         s_r = (m_step == 0) ? ($urandom_range(0, 149) == 0) : ($urandom_range(0, 9) == 0);
         a_r = ($urandom_range(0, 3) == 0);
         b_r = ($urandom_range(0, 15) == 0);
         cycle(s_r, a_r, b_r);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
